// File: rtl/l1_pkg.sv
// Shared types and address helpers for the set-associative L1 cache.
package l1_pkg;

    localparam int unsigned L1_WORD_SIZE  = 32;
    localparam int unsigned L1_TAG_SIZE   = 2;
    localparam int unsigned L1_INDEX_SIZE = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [L1_TAG_SIZE-1:0] tag;
        logic [L1_WORD_SIZE-1:0] data;
    } line_t;

    // Tag is the top TAG_SIZE bits of the address
    function automatic logic [L1_TAG_SIZE-1:0] get_tag(input logic [L1_WORD_SIZE-1:0] addr);
        return L1_TAG_SIZE'(addr >> (L1_WORD_SIZE - L1_TAG_SIZE));
    endfunction

    // Index is the INDEX_SIZE bits directly below the tag
    function automatic logic [L1_INDEX_SIZE-1:0] get_index(input logic [L1_WORD_SIZE-1:0] addr);
        return L1_INDEX_SIZE'(addr >> (L1_WORD_SIZE - L1_TAG_SIZE - L1_INDEX_SIZE));
    endfunction

endpackage

// File: rtl/l1_sa_cache_if.sv
// Core-side request/response and next-level memory signals of the L1 cache.
interface l1_sa_cache_if
    import l1_pkg::*;
#(
    parameter int unsigned WORD_SIZE = L1_WORD_SIZE
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_data;
    logic                 resp_hit;
    logic                 flush;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_resp_valid;
    logic [WORD_SIZE-1:0] mem_rdata;

    // Cache side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_hit,
        output mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    // Core plus memory environment side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_hit,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l1_tag_match.sv
// Combinational tag compare across the ways of one set.
module l1_tag_match #(
    parameter  int unsigned WAYS     = 2,
    parameter  int unsigned TAG_SIZE = 2,
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]               valid_i,
    input  logic [WAYS-1:0][TAG_SIZE-1:0] tags_i,
    input  logic [TAG_SIZE-1:0]           tag_i,
    output logic                          hit_o,
    output logic [WAY_W-1:0]              hit_way_o,
    output logic                          first_inv_valid_o,
    output logic [WAY_W-1:0]              first_inv_way_o
);

    logic hit_found;
    logic inv_found;

    // Lowest-index matching way and lowest-index invalid way
    always_comb begin
        hit_found       = 1'b0;
        inv_found       = 1'b0;
        hit_way_o       = '0;
        first_inv_way_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_i[w] && (tags_i[w] == tag_i) && !hit_found) begin
                hit_found = 1'b1;
                hit_way_o = WAY_W'(w);
            end
            if (!valid_i[w] && !inv_found) begin
                inv_found       = 1'b1;
                first_inv_way_o = WAY_W'(w);
            end
        end
        hit_o             = hit_found;
        first_inv_valid_o = inv_found;
    end

endmodule

// File: rtl/l1_sa_cache.sv
// N-way set-associative write-through, write-allocate L1 cache, one word per line.
// Optional L1_STATS_EN adds saturating hit_count / miss_count outputs.
module l1_sa_cache
    import l1_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = L1_WORD_SIZE,
    parameter int unsigned TAG_SIZE   = L1_TAG_SIZE,
    parameter int unsigned INDEX_SIZE = L1_INDEX_SIZE,
    parameter int unsigned WAYS       = 2
) (
    input logic          clk,
    input logic          rst_n,
    l1_sa_cache_if.slave bus
`ifdef L1_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
`endif
);

    localparam int unsigned SETS  = 2 ** INDEX_SIZE;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t               state_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 hit_q;
    logic [WAY_W-1:0]     victim_q;
    line_t                lines_q [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q    [SETS];

    logic                 resp_valid_q;
    logic [WORD_SIZE-1:0] resp_data_q;
    logic                 resp_hit_q;
    logic                 mem_req_valid_q;
    logic                 mem_we_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;

    logic [INDEX_SIZE-1:0]         idx_c;
    logic [TAG_SIZE-1:0]           tag_c;
    logic [WAYS-1:0]               set_valid_c;
    logic [WAYS-1:0][TAG_SIZE-1:0] set_tags_c;
    logic                          hit_c;
    logic [WAY_W-1:0]              hit_way_c;
    logic                          inv_valid_c;
    logic [WAY_W-1:0]              inv_way_c;
    logic [WAY_W-1:0]              victim_c;
    logic [WAY_W-1:0]              rr_next_c;

    assign idx_c = get_index(addr_q);
    assign tag_c = get_tag(addr_q);

    // Gather valid bits and tags of the addressed set for the comparator
    always_comb begin
        set_valid_c = '0;
        set_tags_c  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid_c[w] = lines_q[idx_c][w].valid;
            set_tags_c[w]  = lines_q[idx_c][w].tag;
        end
    end

    l1_tag_match #(
        .WAYS     (WAYS),
        .TAG_SIZE (TAG_SIZE)
    ) u_tag_match (
        .valid_i           (set_valid_c),
        .tags_i            (set_tags_c),
        .tag_i             (tag_c),
        .hit_o             (hit_c),
        .hit_way_o         (hit_way_c),
        .first_inv_valid_o (inv_valid_c),
        .first_inv_way_o   (inv_way_c)
    );

    // Prefer an empty way; only a full set consumes the round-robin pointer
    assign victim_c  = inv_valid_c ? inv_way_c : rr_q[idx_c];
    assign rr_next_c = (rr_q[idx_c] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_c] + WAY_W'(1);

    // Controller FSM with line storage, replacement state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            data_q          <= '0;
            hit_q           <= 1'b0;
            victim_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_hit_q      <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    lines_q[s][w] <= '0;
                end
            end
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.flush) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            for (int unsigned w = 0; w < WAYS; w++) begin
                                lines_q[s][w].valid <= 1'b0;
                            end
                        end
                    end else if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_q <= hit_c;
                    if (!hit_c) begin
                        victim_q <= victim_c;
                        if (!inv_valid_c) begin
                            rr_q[idx_c] <= rr_next_c;
                        end
                    end
                    if (we_q) begin
                        data_q <= wdata_q;
                        if (hit_c) begin
                            lines_q[idx_c][hit_way_c].data <= wdata_q;
                        end else begin
                            lines_q[idx_c][victim_c] <= '{valid: 1'b1, tag: tag_c, data: wdata_q};
                        end
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= 1'b1;
                        mem_addr_q      <= addr_q;
                        mem_wdata_q     <= wdata_q;
                        state_q         <= MEM_REQ;
                    end else if (hit_c) begin
                        data_q  <= lines_q[idx_c][hit_way_c].data;
                        state_q <= RESP;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= 1'b0;
                        mem_addr_q      <= addr_q;
                        mem_wdata_q     <= wdata_q;
                        state_q         <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_we_q        <= 1'b0;
                        state_q         <= mem_we_q ? RESP : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        lines_q[idx_c][victim_q] <= '{valid: 1'b1, tag: tag_c, data: bus.mem_rdata};
                        data_q  <= bus.mem_rdata;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= data_q;
                    resp_hit_q   <= hit_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state_q == IDLE) && !bus.flush;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

`ifdef L1_STATS_EN
    logic [WORD_SIZE-1:0] hit_cnt_q;
    logic [WORD_SIZE-1:0] miss_cnt_q;

    // Saturating lookup counters; flush leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit_c) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + WORD_SIZE'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + WORD_SIZE'(1);
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_sa_cache.sv
// Scoreboard bench for l1_sa_cache: reads/writes, replacement, stalls, flush and reset abort.
module tb_l1_sa_cache;
    import l1_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   resp_cyc = 0;
    int   acc_cyc  = 0;
    exp_t sb [$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l1_sa_cache_if #(.WORD_SIZE(32)) bus ();

`ifdef L1_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    l1_sa_cache #(
        .WORD_SIZE  (32),
        .TAG_SIZE   (2),
        .INDEX_SIZE (4),
        .WAYS       (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef L1_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Pop the scoreboard on every response pulse
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            resp_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", bus.resp_data, mon_e.data);
                check("resp_hit", 32'(bus.resp_hit), 32'(mon_e.hit));
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_hit, input logic [31:0] exp_data,
                          input logic exp_mem, input logic [31:0] rdata, input int stall);
        int          n;
        int          hs_cyc;
        int          mr_cyc;
        logic        saw_mem;
        logic [31:0] wd_snap;
        exp_t        e;
        hs_cyc  = 0;
        mr_cyc  = 0;
        saw_mem = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        e.data  = exp_data;
        e.hit   = exp_hit;
        sb.push_back(e);
        bus.req_valid = 1'b0;
        if (exp_mem) begin
            n = 0;
            while (!bus.mem_req_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({name, ":mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
            check({name, ":mem_addr"}, bus.mem_addr, addr);
            check({name, ":mem_we"}, 32'(bus.mem_we), 32'(we));
            if (we) check({name, ":mem_wdata"}, bus.mem_wdata, wdata);
            wd_snap = bus.mem_wdata;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({name, ":stall_valid"}, 32'(bus.mem_req_valid), 32'd1);
                check({name, ":stall_addr"}, bus.mem_addr, addr);
                check({name, ":stall_wdata"}, bus.mem_wdata, wd_snap);
                check({name, ":stall_req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            bus.mem_req_ready = 1'b1;
            @(posedge clk);
            #1;
            hs_cyc = cyc;
            bus.mem_req_ready = 1'b0;
            if (!we) begin
                @(negedge clk);
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = rdata;
                @(posedge clk);
                #1;
                mr_cyc = cyc;
                bus.mem_resp_valid = 1'b0;
                bus.mem_rdata      = 32'hFFFF_FFFF;
            end
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            if (bus.mem_req_valid) saw_mem = 1'b1;
            n++;
        end
        check({name, ":resp_timeout"}, 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
        if (exp_mem) begin
            check({name, ":mem_latency"}, 32'(resp_cyc - (we ? hs_cyc : mr_cyc)), 32'd1);
        end else begin
            check({name, ":hit_latency"}, 32'(resp_cyc - acc_cyc), 32'd2);
            check({name, ":no_mem_req"}, 32'(saw_mem), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":req_ready"}, 32'(bus.req_ready), 32'd1);
        check({name, ":resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({name, ":resp_hit"}, 32'(bus.resp_hit), 32'd0);
        check({name, ":resp_data"}, bus.resp_data, 32'd0);
        check({name, ":mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({name, ":mem_we"}, 32'(bus.mem_we), 32'd0);
        check({name, ":mem_addr"}, bus.mem_addr, 32'd0);
        check({name, ":mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    localparam logic [31:0] JUNK = 32'hDEAD_0000;

    initial begin
        int n;
        int flush_cyc;
        bus.req_valid      = 1'b0;
        bus.req_we         = 1'b0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Miss then hit on set 1 tag 0
        do_req("rd_miss0", 1'b0, 32'h0400_0000, JUNK, 1'b0, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 0);
        do_req("rd_hit0",  1'b0, 32'h0400_0000, JUNK, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0, 0);
        // Write miss allocates the free way
        do_req("wr_miss1", 1'b1, 32'h4400_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 32'h0, 0);
        do_req("rd_hit1",  1'b0, 32'h4400_0000, JUNK, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 0);
        // Full set: round robin evicts way 0, then way 1, then way 0
        do_req("rd_evict2", 1'b0, 32'h8400_0000, JUNK, 1'b0, 32'hBEEF_0084, 1'b1, 32'hBEEF_0084, 0);
        do_req("rd_remiss0", 1'b0, 32'h0400_0000, JUNK, 1'b0, 32'hA5A5_0002, 1'b1, 32'hA5A5_0002, 0);
        do_req("rd_hit2",  1'b0, 32'h8400_0000, JUNK, 1'b1, 32'hBEEF_0084, 1'b0, 32'h0, 0);
        do_req("rd_remiss1", 1'b0, 32'h4400_0000, JUNK, 1'b0, 32'h5555_0044, 1'b1, 32'h5555_0044, 0);
        // Aliasing below the index, then write hit
        do_req("rd_alias", 1'b0, 32'h0400_0ABC, JUNK, 1'b1, 32'hA5A5_0002, 1'b0, 32'h0, 0);
        do_req("wr_hit",   1'b1, 32'h0400_0000, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0, 0);
        do_req("rd_after_wr", 1'b0, 32'h0400_0000, JUNK, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 0);
        // Memory request backpressure
        do_req("rd_stall", 1'b0, 32'h0800_0000, JUNK, 1'b0, 32'h0000_0802, 1'b1, 32'h0000_0802, 5);

        // Flush alone, then the same line misses
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush:req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        do_req("rd_post_flush", 1'b0, 32'h0800_0000, JUNK, 1'b0, 32'h0000_0803, 1'b1, 32'h0000_0803, 0);

        // Flush concurrent with a request: request held, accepted next cycle
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0800_0000;
        #1;
        check("flush_req:req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush_cyc = cyc;
        bus.flush = 1'b0;
        do_req("rd_flush_req", 1'b0, 32'h0800_0000, JUNK, 1'b0, 32'h0000_0804, 1'b1, 32'h0000_0804, 0);
        check("flush_req:accept_cycle", 32'(acc_cyc - flush_cyc), 32'd1);

`ifdef L1_STATS_EN
        check("stats:hits", hit_count, 32'd6);
        check("stats:misses", miss_count, 32'd8);
`endif

        // Reset while waiting for refill data aborts the request
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0C00_0000;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort:mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        do_req("rd_after_abort", 1'b0, 32'h0C00_0000, JUNK, 1'b0, 32'h0000_0C03, 1'b1, 32'h0000_0C03, 0);
        do_req("rd_hit_after_abort", 1'b0, 32'h0C00_0000, JUNK, 1'b1, 32'h0000_0C03, 1'b0, 32'h0, 0);

`ifdef L1_STATS_EN
        check("stats_rst:hits", hit_count, 32'd1);
        check("stats_rst:misses", miss_count, 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
